// File: rtl/seq_alu.sv
// seq_alu: sequential ALU. Ordinary ops take one cycle, and each result is held until the consumer takes it.
// Defining SEQ_ALU_MUL_EN builds a WIDTH-cycle shift-add MUL (opcode 1011); otherwise 1011 is illegal.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] reg_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             z,
    output logic             c,
    output logic             n,
    output logic             v,
    output logic             err
);
    localparam logic [3:0] OP_ADD = 4'b0010, OP_SUB = 4'b0011, OP_SHL = 4'b0100,
                           OP_SHR = 4'b0101, OP_AND = 4'b0110, OP_OR  = 4'b0111,
                           OP_XOR = 4'b1000, OP_CMP = 4'b1010;

    typedef struct packed {
        logic [WIDTH-1:0] lo;
        logic             z, c, n, v, err;
    } res_t;

`ifdef SEQ_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1011;
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

    state_t           state, state_nxt;
    res_t             alu, res_q;
    logic             accept, is_mul;
    logic [WIDTH-1:0] lo;
    logic             cf, vf, ef;
    logic [WIDTH:0]   add_x, sub_x, shl_x, shr_x;

    assign accept    = in_valid && (state == IDLE);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign result    = res_q.lo;
    assign z         = res_q.z;
    assign c         = res_q.c;
    assign n         = res_q.n;
    assign v         = res_q.v;
    assign err       = res_q.err;

    // One extra bit on each side catches the carry/borrow or the last bit shifted out.
    assign add_x = {1'b0, acc_in} + {1'b0, reg_in};
    assign sub_x = {1'b0, acc_in} - {1'b0, reg_in};
    assign shl_x = {1'b0, acc_in} << reg_in;
    assign shr_x = {acc_in, 1'b0} >> reg_in;

    always_comb begin
        lo = '0;
        cf = 1'b0;
        vf = 1'b0;
        ef = 1'b0;
        case (op)
            OP_ADD: begin
                lo = add_x[WIDTH-1:0];
                cf = add_x[WIDTH];
                vf = (acc_in[WIDTH-1] == reg_in[WIDTH-1]) && (add_x[WIDTH-1] != acc_in[WIDTH-1]);
            end
            OP_SUB: begin
                lo = sub_x[WIDTH-1:0];
                cf = sub_x[WIDTH];
                vf = (acc_in[WIDTH-1] != reg_in[WIDTH-1]) && (sub_x[WIDTH-1] != acc_in[WIDTH-1]);
            end
            OP_SHL: begin
                lo = shl_x[WIDTH-1:0];
                cf = shl_x[WIDTH];
            end
            OP_SHR: begin
                lo = shr_x[WIDTH:1];
                cf = shr_x[0];
            end
            OP_AND: lo = acc_in & reg_in;
            OP_OR:  lo = acc_in | reg_in;
            OP_XOR: lo = acc_in ^ reg_in;
            OP_CMP: lo = '0;
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: lo = '0;
`endif
            default: ef = 1'b1;
        endcase
        alu.lo  = lo;
        alu.c   = cf;
        alu.v   = vf;
        alu.err = ef;
        alu.z   = (op == OP_CMP) ? (acc_in == reg_in) : (lo == '0);
        alu.n   = (op == OP_CMP) ? (acc_in < reg_in)  : lo[WIDTH-1];
    end

`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0]   mcand, hi_q;
    logic [2*WIDTH-1:0] prod, prod_nxt;
    logic [WIDTH:0]     psum;
    logic [CW-1:0]      cnt;
    logic               mul_last;

    // prod holds {partial sum, remaining multiplier bits}; one multiplier bit retires per cycle.
    assign is_mul    = (op == OP_MUL);
    assign psum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_nxt  = {psum, prod[WIDTH-1:1]};
    assign mul_last  = (cnt == CW'(WIDTH-1));
    assign result_hi = hi_q;
`else
    assign is_mul    = 1'b0;
    assign result_hi = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
`ifdef SEQ_ALU_MUL_EN
            IDLE: if (in_valid) state_nxt = is_mul ? BUSY : HOLD;
            BUSY: if (mul_last) state_nxt = HOLD;
`else
            IDLE: if (in_valid) state_nxt = HOLD;
`endif
            HOLD: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
`ifdef SEQ_ALU_MUL_EN
            hi_q  <= '0;
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
`endif
        end else begin
            if (accept && !is_mul) begin
                res_q <= alu;
`ifdef SEQ_ALU_MUL_EN
                hi_q  <= '0;
`endif
            end
`ifdef SEQ_ALU_MUL_EN
            if (accept && is_mul) begin
                mcand <= acc_in;
                prod  <= {{WIDTH{1'b0}}, reg_in};
                cnt   <= '0;
            end else if (state == BUSY) begin
                prod <= prod_nxt;
                cnt  <= cnt + 1'b1;
                if (mul_last) begin
                    res_q <= '{lo: prod_nxt[WIDTH-1:0], z: (prod_nxt[WIDTH-1:0] == '0),
                               c: (prod_nxt[2*WIDTH-1:WIDTH] != '0), n: prod_nxt[WIDTH-1],
                               v: 1'b0, err: 1'b0};
                    hi_q  <= prod_nxt[2*WIDTH-1:WIDTH];
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed corner cases plus random ops against an arithmetic reference model.
module tb_seq_alu;
    localparam int W = 8;
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] acc_in = '0, reg_in = '0;
    logic         in_ready, out_valid, z, c, n, v, err;
    logic [W-1:0] result, result_hi;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .acc_in(acc_in), .reg_in(reg_in), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .z(z), .c(c), .n(n), .v(v), .err(err)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        longint lo, hi;
        bit     z, c, n, v, err;
        int     lat;
    } exp_t;

    function automatic longint sgn(input longint x);
        longint half = longint'(1) << (W - 1);
        return (x >= half) ? x - 2 * half : x;
    endfunction

    function automatic exp_t model(input int o, input longint a, input longint b);
        exp_t   e;
        longint m = longint'(1) << W;
        longint half = m / 2;
        longint s;
        e = '{lo: 0, hi: 0, z: 0, c: 0, n: 0, v: 0, err: 0, lat: 1};
        case (o)
            2: begin
                s = a + b; e.lo = s % m; e.c = (s >= m);
                s = sgn(a) + sgn(b); e.v = (s < -half) || (s >= half);
            end
            3: begin
                e.lo = (a - b + m) % m; e.c = (a < b);
                s = sgn(a) - sgn(b); e.v = (s < -half) || (s >= half);
            end
            4: begin
                e.lo = (b < W) ? (a * (longint'(1) << b)) % m : 0;
                e.c  = (b >= 1 && b <= W) ? ((a >> (W - b)) & 1) != 0 : 0;
            end
            5: begin
                e.lo = (b < W) ? a / (longint'(1) << b) : 0;
                e.c  = (b >= 1 && b <= W) ? ((a >> (b - 1)) & 1) != 0 : 0;
            end
            6: e.lo = a & b;
            7: e.lo = a | b;
            8: e.lo = a ^ b;
            10: begin e.z = (a == b); e.n = (a < b); end
            11: if (MUL_EN) begin
                s = a * b; e.lo = s % m; e.hi = s / m; e.c = (e.hi != 0); e.lat = W + 1;
            end else e.err = 1;
            default: e.err = 1;
        endcase
        if (o != 10) begin
            e.z = (e.lo == 0);
            e.n = (e.lo >= half);
        end
        return e;
    endfunction

    // Called and returns at a negedge with the DUT idle.
    task automatic run_op(input int o, input int a, input int b, input int hold, input string tag);
        exp_t e;
        int   guard, lat;
        e = model(o, longint'(a), longint'(b));
        guard = 0;
        while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
        chk({tag, "_in_ready"}, in_ready, 1);
        op = 4'(o); acc_in = W'(a); reg_in = W'(b); in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = 4'($urandom); acc_in = W'($urandom); reg_in = W'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            chk({tag, "_busy_rdy"}, in_ready, 0);
        end while (!out_valid && lat < 100);
        chk({tag, "_latency"}, lat, e.lat);
        chk({tag, "_result"}, result, e.lo);
        chk({tag, "_result_hi"}, result_hi, e.hi);
        chk({tag, "_zcnv_err"}, {z, c, n, v, err}, {e.z, e.c, e.n, e.v, e.err});
        repeat (hold) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, {out_valid, in_ready}, 2'b10);
            chk({tag, "_hold_result"}, {result_hi, result}, {W'(e.hi), W'(e.lo)});
            chk({tag, "_hold_flags"}, {z, c, n, v, err}, {e.z, e.c, e.n, e.v, e.err});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_release"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int o, b;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {out_valid, result, result_hi, z, c, n, v, err}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        run_op(4'b0010, 'h7F, 'h01, 0, "add_ovf");
        run_op(4'b0011, 'h03, 'h05, 0, "sub_borrow");
        run_op(4'b1010, 'h05, 'h05, 0, "cmp_eq");
        run_op(4'b1010, 'h03, 'h09, 1, "cmp_lt");
        run_op(4'b1011, 'hFF, 'hFF, 0, "mul_ff");
        run_op(4'b0100, 'h81, 1, 5, "shl_bp");
        run_op(4'b0100, 'hA5, 0, 0, "shl_0");
        run_op(4'b0100, 'hA5, W, 0, "shl_w");
        run_op(4'b0100, 'hFF, W + 1, 0, "shl_w1");
        run_op(4'b0101, 'h80, W - 1, 0, "shr_wm1");
        run_op(4'b0101, 'h80, W, 0, "shr_w");
        run_op(4'b1011, 'h12, 'h34, 0, "op_1011");
        run_op(4'b1111, 'h12, 'h34, 2, "op_1111");

        // Reset 3 cycles into a MUL: outputs clear and no result ever appears.
        op = 4'b1011; acc_in = 'hFF; reg_in = 'hFF; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {out_valid, result, result_hi, z, c, n, v, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            chk("abort_no_valid", out_valid, 0);
        end

        for (int i = 0; i < 150; i++) begin
            o = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(2, 11));
            b = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W + 2)) : int'($urandom_range(0, 255));
            run_op(o, int'($urandom_range(0, 255)), b, int'($urandom_range(0, 2)), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 op  input  4  opcode: 0010 ADD, 0011 SUB, 0100 SHL, 0101 SHR, 0110 AND, 0111 OR, 1000 XOR, 1010 CMP, 1011 MUL; others illegal.
REQ-007 acc_in  input  WIDTH  operand A.
REQ-008 reg_in  input  WIDTH  operand B; the shift amount for SHL/SHR.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  WIDTH  result low word.
REQ-012 result_hi  output  WIDTH  MUL high word; 0 for all other ops.
REQ-013 z, c, n, v  output  1 each  zero, carry/borrow, negative, signed-overflow flags.
REQ-014 err  output  1  illegal opcode on the current result.

Function
REQ-015 FSM states are IDLE, BUSY and HOLD; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in HOLD.
REQ-016 Accept occurs on an edge with in_valid=1 and in_ready=1; op and operands are captured at that edge, and inputs are ignored at all other times.
REQ-017 Non-MUL accept: IDLE->HOLD at the accept edge, so out_valid=1 in the cycle after the accept (latency 1).
REQ-018 MUL accept: IDLE->BUSY; an iterative shift-add multiply runs for exactly WIDTH cycles, then BUSY->HOLD, so out_valid rises WIDTH+1 cycles after the accept.
REQ-019 HOLD: result, result_hi, flags and err SHALL stay stable until an edge with out_ready=1, which moves the FSM to HOLD->IDLE; there is no same-cycle accept, so throughput is at most one op per 2 cycles.
REQ-020 ADD/SUB: result = (A+B) or (A-B) mod 2^WIDTH; c = carry out for ADD, or borrow (A<B unsigned) for SUB; v = two's-complement overflow.
REQ-021 SHL/SHR: logical shift by B; if B>=WIDTH, result = 0; c = last bit shifted out, and 0 when B=0 or B>WIDTH; v=0.
REQ-022 AND/OR/XOR: bitwise result; c=v=0.
REQ-023 CMP: result=0; z=(A==B); n=(A<B unsigned); c=v=0.
REQ-024 MUL: unsigned full product, with the low word on result and the high word on result_hi; c=(result_hi!=0); v=0.
REQ-025 For all ops except CMP: z=(result==0) and n=result[WIDTH-1].
REQ-026 Illegal op: takes the 1-cycle path; result = 0, result_hi = 0, err = 1, z = 1, c = n = v = 0. For every legal op, err = 0.
REQ-027 Outputs SHALL be registered; no combinational path from any input to any output except none.

Reset
REQ-028 While rst_n=0: state = IDLE; out_valid = 0; result, result_hi, z, c, n, v and err = 0; the MUL counter and partial product = 0.
REQ-029 Reset asserted in BUSY or HOLD aborts the operation; no result is delivered afterwards.
REQ-030 in_ready SHALL be 1 on the first cycle after rst_n deasserts.

Configuration
REQ-031 Macro SEQ_ALU_MUL_EN: when defined, MUL is implemented as in REQ-018/REQ-024.
REQ-032 When SEQ_ALU_MUL_EN is undefined: no BUSY state and no multiplier logic; opcode 1011 is treated as illegal per REQ-026; result_hi is tied to 0.

Verification
REQ-033 WIDTH=8, ADD 0x7F+0x01 -> result=0x80, n=1, v=1, c=0, z=0; out_valid one cycle after accept.
REQ-034 SUB 0x03-0x05 -> result=0xFE, c=1, n=1, v=0; then CMP 0x05,0x05 -> z=1, n=0, result=0x00.
REQ-035 MUL 0xFF*0xFF (macro defined) -> result=0x01, result_hi=0xFE, c=1; out_valid exactly 9 cycles after accept; in_ready=0 throughout.
REQ-036 Backpressure: SHL 0x81 by 1 with out_ready=0 for 5 cycles -> result=0x02 and c=1 held stable, in_ready=0; out_ready=1 -> IDLE the next cycle.
REQ-037 rst_n pulsed low 3 cycles into MUL -> all outputs 0 immediately, and no out_valid after release.
REQ-038 Macro undefined: op 1011, and also op 1111 -> err=1, result=0, z=1 after 1 cycle.
